uart_tx_fifo_sensor: RTL

Downstream consumer of dht11_uart_sender. Accepts bytes on push_tx/tx_din into a synchronous FIFO, then serialises them as 8N1 UART frames on tx, LSB first.
Replaces the bare UART transmitter so a 24-byte report burst is buffered without loss. tx_busy is the back-pressure signal the sender polls.

---
 rtl/uart_sensor_pkg.sv | 17 +
 rtl/uart_tx_fifo_sensor_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo_sensor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_sensor_pkg.sv
// Shared types and helpers for the buffered sensor UART transmitter.
// Holds the serialiser state encoding and the baud divider calculation.
package uart_sensor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic int calc_baud_div(input int clk_freq,
                                         input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sensor_fifo.sv
// Synchronous byte FIFO feeding the sensor UART serialiser.
// Exposes both the registered and the next-state occupancy.
module fifo_sync_sensor #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               din_i,
    output logic [7:0]               dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_nxt_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o      = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_o = count_d;

endmodule

// File: rtl/uart_tx_fifo_sensor.sv
// Buffered 8N1 UART transmitter for the DHT11 report sender.
// Bytes queue in a FIFO and leave LSB first; tx_busy gives early back-pressure.
module uart_tx_fifo_sensor
    import uart_sensor_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_tx,
    input  logic [7:0] tx_din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_active,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BUSY_CNT = CW'(FIFO_DEPTH - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_nxt;
    logic          fifo_full;
    logic          fifo_is_empty;
    logic          pop;
    logic          baud_last;

    fifo_sync_sensor #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_tx),
        .pop_i       (pop),
        .din_i       (tx_din),
        .dout_o      (fifo_dout),
        .count_o     (fifo_count),
        .count_nxt_o (fifo_count_nxt),
        .full_o      (fifo_full),
        .empty_o     (fifo_is_empty)
    );

    assign baud_last = (baud_q == LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_is_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Busy looks at the next-state count so it is valid one slot early.
    assign busy_d = (fifo_count_nxt >= BUSY_CNT);
    assign ovf_d  = ovf_q | (push_tx & fifo_full & ~pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign tx_done    = (state_q == STOP) && baud_last;
    assign tx_active  = (state_q != IDLE);
    assign fifo_empty = (fifo_count == '0);
    assign overflow   = ovf_q;

endmodule
